// File: rtl/requant_maxpool_core.sv
// requant_maxpool_core
// Per-channel requantisation (arithmetic right shift, optional ReLU, signed
// saturation to O_BW) followed by non-overlapping PxP max pooling. Pooled
// pixels leave in raster order with their pooled coordinates, a frame-done
// pulse on the last one, and sticky per-channel saturation flags.
module requant_maxpool_core #(
    parameter int CO      = 3,
    parameter int I_BW    = 20,
    parameter int O_BW    = 16,
    parameter int IW      = 24,
    parameter int IH      = 24,
    parameter int P       = 2,
    parameter int SHIFT_W = 5,
    localparam int POW    = IW / P,
    localparam int POH    = IH / P,
    localparam int XW     = (POW > 1) ? $clog2(POW) : 1,
    localparam int YW     = (POH > 1) ? $clog2(POH) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SHIFT_W-1:0]   i_cfg_shift,
    input  logic                 i_cfg_relu,
    input  logic                 i_frame_rst,
    input  logic                 i_sat_clr,
    input  logic                 i_in_valid,
    input  logic [CO*I_BW-1:0]   i_in_fmap,
    output logic                 o_ot_valid,
    output logic [CO*O_BW-1:0]   o_ot_fmap,
    output logic [XW-1:0]        o_ot_x,
    output logic [YW-1:0]        o_ot_y,
    output logic                 o_frame_done,
    output logic [CO-1:0]        o_sat_flag
);

    localparam int XCW = (IW > 1) ? $clog2(IW) : 1;
    localparam int YCW = (IH > 1) ? $clog2(IH) : 1;

    // Saturation bounds expressed at the input width so the compare is exact.
    localparam logic signed [I_BW-1:0] SAT_MAX = {{(I_BW-O_BW+1){1'b0}}, {(O_BW-1){1'b1}}};
    localparam logic signed [I_BW-1:0] SAT_MIN = {{(I_BW-O_BW+1){1'b1}}, {(O_BW-1){1'b0}}};

    logic [XCW-1:0]      x_cnt;
    logic [YCW-1:0]      y_cnt;
    logic [SHIFT_W-1:0]  cfg_shift_q;
    logic                cfg_relu_q;

    logic                accept;
    logic                frame_start;
    logic [SHIFT_W-1:0]  shift_eff;
    logic                relu_eff;

    logic signed [I_BW-1:0] sh_v  [CO];
    logic signed [O_BW-1:0] sat_v [CO];
    logic [CO-1:0]          sat_evt;

    int                  xi;
    int                  yi;
    logic                in_grid;
    logic [XW-1:0]       gx_d;
    logic [YW-1:0]       gy_d;
    logic                px_first_d;
    logic                px_last_d;
    logic                py_first_d;
    logic                py_last_d;

    logic                   s1_valid;
    logic signed [O_BW-1:0] s1_v [CO];
    logic                   s1_grid;
    logic [XW-1:0]          s1_gx;
    logic [YW-1:0]          s1_gy;
    logic                   s1_px_first;
    logic                   s1_px_last;
    logic                   s1_py_first;
    logic                   s1_py_last;

    logic signed [O_BW-1:0] h_q [CO];
    logic signed [O_BW-1:0] h_n [CO];
    logic signed [O_BW-1:0] m_n [CO];
    logic signed [O_BW-1:0] lb  [CO][POW];

    // A pixel arriving together with a resync is discarded.
    assign accept      = i_in_valid & ~i_frame_rst;
    assign frame_start = (x_cnt == '0) && (y_cnt == '0);
    // The first pixel of a frame already uses the config it latches.
    assign shift_eff   = frame_start ? i_cfg_shift : cfg_shift_q;
    assign relu_eff    = frame_start ? i_cfg_relu  : cfg_relu_q;

    // Requantise every channel of the incoming pixel: shift, ReLU, saturate.
    always_comb begin
        sat_evt = '0;
        for (int c = 0; c < CO; c++) begin
            sh_v[c] = $signed(i_in_fmap[c*I_BW +: I_BW]) >>> shift_eff;
            if (relu_eff && sh_v[c][I_BW-1]) begin
                sh_v[c] = '0;
            end
            if (sh_v[c] > SAT_MAX) begin
                sat_v[c]   = SAT_MAX[O_BW-1:0];
                sat_evt[c] = 1'b1;
            end else if (sh_v[c] < SAT_MIN) begin
                sat_v[c]   = SAT_MIN[O_BW-1:0];
                sat_evt[c] = 1'b1;
            end else begin
                sat_v[c] = sh_v[c][O_BW-1:0];
            end
        end
    end

    // Pool-window geometry of the current input position.
    always_comb begin
        xi         = int'(x_cnt);
        yi         = int'(y_cnt);
        in_grid    = (xi < POW * P) && (yi < POH * P);
        gx_d       = XW'(xi / P);
        gy_d       = YW'(yi / P);
        px_first_d = (xi % P) == 0;
        px_last_d  = (xi % P) == P - 1;
        py_first_d = (yi % P) == 0;
        py_last_d  = (yi % P) == P - 1;
    end

    // Raster position counters and per-frame config latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_cnt       <= '0;
            y_cnt       <= '0;
            cfg_shift_q <= '0;
            cfg_relu_q  <= 1'b0;
        end else if (i_frame_rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (i_in_valid) begin
            if (frame_start) begin
                cfg_shift_q <= i_cfg_shift;
                cfg_relu_q  <= i_cfg_relu;
            end
            if (x_cnt == XCW'(IW - 1)) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == YCW'(IH - 1)) ? '0 : y_cnt + YCW'(1);
            end else begin
                x_cnt <= x_cnt + XCW'(1);
            end
        end
    end

    // Stage 1 register: requantised channels plus window geometry; sticky flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid    <= 1'b0;
            s1_grid     <= 1'b0;
            s1_gx       <= '0;
            s1_gy       <= '0;
            s1_px_first <= 1'b0;
            s1_px_last  <= 1'b0;
            s1_py_first <= 1'b0;
            s1_py_last  <= 1'b0;
            o_sat_flag  <= '0;
            for (int c = 0; c < CO; c++) begin
                s1_v[c] <= '0;
            end
        end else begin
            s1_valid    <= accept;
            s1_grid     <= in_grid;
            s1_gx       <= gx_d;
            s1_gy       <= gy_d;
            s1_px_first <= px_first_d;
            s1_px_last  <= px_last_d;
            s1_py_first <= py_first_d;
            s1_py_last  <= py_last_d;
            for (int c = 0; c < CO; c++) begin
                s1_v[c] <= sat_v[c];
            end
            // A new saturation in the clearing cycle wins over the clear.
            o_sat_flag <= (i_sat_clr ? '0 : o_sat_flag) | (accept ? sat_evt : '0);
        end
    end

    // Horizontal running max, then vertical max against the line buffer.
    always_comb begin
        for (int c = 0; c < CO; c++) begin
            h_n[c] = (s1_px_first || (s1_v[c] > h_q[c])) ? s1_v[c] : h_q[c];
            m_n[c] = (s1_py_first || (h_n[c] > lb[c][s1_gx])) ? h_n[c] : lb[c][s1_gx];
        end
    end

    // Stage 2: update running max and line buffer, register pooled output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_ot_valid   <= 1'b0;
            o_ot_fmap    <= '0;
            o_ot_x       <= '0;
            o_ot_y       <= '0;
            o_frame_done <= 1'b0;
            for (int c = 0; c < CO; c++) begin
                h_q[c] <= '0;
                for (int g = 0; g < POW; g++) begin
                    lb[c][g] <= '0;
                end
            end
        end else begin
            o_ot_valid   <= 1'b0;
            o_frame_done <= 1'b0;
            if (i_frame_rst) begin
                for (int c = 0; c < CO; c++) begin
                    h_q[c] <= '0;
                end
            end else if (s1_valid && s1_grid) begin
                for (int c = 0; c < CO; c++) begin
                    h_q[c] <= h_n[c];
                end
                if (s1_px_last) begin
                    if (!s1_py_last) begin
                        for (int c = 0; c < CO; c++) begin
                            lb[c][s1_gx] <= m_n[c];
                        end
                    end else begin
                        for (int c = 0; c < CO; c++) begin
                            o_ot_fmap[c*O_BW +: O_BW] <= m_n[c];
                        end
                        o_ot_valid   <= 1'b1;
                        o_ot_x       <= s1_gx;
                        o_ot_y       <= s1_gy;
                        o_frame_done <= (s1_gx == XW'(POW - 1)) && (s1_gy == YW'(POH - 1));
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_requant_maxpool_core.sv
// Directed bench for requant_maxpool_core on a 4x4, 2-channel, 2x2-pool setup.
module tb_requant_maxpool_core;

    localparam int CO      = 2;
    localparam int I_BW    = 12;
    localparam int O_BW    = 8;
    localparam int IW      = 4;
    localparam int IH      = 4;
    localparam int P       = 2;
    localparam int SHIFT_W = 5;
    localparam int XW      = 1;
    localparam int YW      = 1;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [SHIFT_W-1:0]  i_cfg_shift = '0;
    logic                i_cfg_relu = 1'b0;
    logic                i_frame_rst = 1'b0;
    logic                i_sat_clr = 1'b0;
    logic                i_in_valid = 1'b0;
    logic [CO*I_BW-1:0]  i_in_fmap = '0;
    logic                o_ot_valid;
    logic [CO*O_BW-1:0]  o_ot_fmap;
    logic [XW-1:0]       o_ot_x;
    logic [YW-1:0]       o_ot_y;
    logic                o_frame_done;
    logic [CO-1:0]       o_sat_flag;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_done = 0;
    int stamp [16];

    typedef struct {
        int x;
        int y;
        int c0;
        int c1;
        int done;
        int cyc;
    } out_t;
    out_t q[$];

    requant_maxpool_core #(
        .CO(CO), .I_BW(I_BW), .O_BW(O_BW), .IW(IW), .IH(IH), .P(P), .SHIFT_W(SHIFT_W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_cfg_shift(i_cfg_shift),
        .i_cfg_relu(i_cfg_relu),
        .i_frame_rst(i_frame_rst),
        .i_sat_clr(i_sat_clr),
        .i_in_valid(i_in_valid),
        .i_in_fmap(i_in_fmap),
        .o_ot_valid(o_ot_valid),
        .o_ot_fmap(o_ot_fmap),
        .o_ot_x(o_ot_x),
        .o_ot_y(o_ot_y),
        .o_frame_done(o_frame_done),
        .o_sat_flag(o_sat_flag)
    );

    always #5 clk = ~clk;

    // Cycle counter used to time-stamp inputs and outputs.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture pooled outputs and any frame-done pulse lacking a valid.
    always @(negedge clk) begin
        if (o_ot_valid) begin
            q.push_back('{int'(o_ot_x), int'(o_ot_y),
                          int'($signed(o_ot_fmap[O_BW-1:0])),
                          int'($signed(o_ot_fmap[2*O_BW-1:O_BW])),
                          int'(o_frame_done), cyc});
        end
        if (o_frame_done && !o_ot_valid) bad_done <= bad_done + 1;
    end

    // Pixel patterns: 0 ramp, 1 saturating, 2 const 40, 3 negative, 4 mixed sign, 5 junk.
    function automatic int pix(input int kind, input int x, input int y, input int ch);
        int r;
        case (kind)
            0: r = y * 4 + x;
            1: r = (ch == 0) ? 1000 : -1000;
            2: r = 40;
            3: r = (ch == 0) ? -(y * 4 + x) - 1
                             : (((x % 2) == 0 && (y % 2) == 0) ? -3 : -(5 + x + y));
            4: r = (ch == 0) ? ((((x + y) % 2) == 0) ? (y * 4 + x) : -(y * 4 + x) - 1)
                             : 6 - (y * 4 + x);
            default: r = 100;
        endcase
        return r;
    endfunction

    // Reference: max over the 2x2 window of the independently requantised pixels.
    function automatic int exp_val(input int kind, input int gx, input int gy, input int ch,
                                   input int sh, input int relu);
        int m;
        int v;
        m = -100000;
        for (int dy = 0; dy < 2; dy++) begin
            for (int dx = 0; dx < 2; dx++) begin
                v = pix(kind, gx * 2 + dx, gy * 2 + dy, ch) >>> sh;
                if (relu != 0 && v < 0) v = 0;
                if (v > 127) v = 127;
                if (v < -128) v = -128;
                if (v > m) m = v;
            end
        end
        return m;
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic send_pix(input int kind, input int idx);
        @(negedge clk);
        i_in_valid = 1'b1;
        i_in_fmap  = {I_BW'(pix(kind, idx % 4, idx / 4, 1)), I_BW'(pix(kind, idx % 4, idx / 4, 0))};
        stamp[idx] = cyc;
    endtask

    task automatic send_frame(input int kind, input int max_gap, input int toggle_idx);
        int g;
        for (int idx = 0; idx < 16; idx++) begin
            g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            repeat (g) begin
                @(negedge clk);
                i_in_valid = 1'b0;
            end
            send_pix(kind, idx);
            if (idx == toggle_idx) i_cfg_shift = 5'd3;
        end
        @(negedge clk);
        i_in_valid = 1'b0;
    endtask

    task automatic check_frame(input int kind, input int sh, input int relu, input string tag);
        int gx;
        int gy;
        repeat (4) @(negedge clk);
        chk($sformatf("%s_count", tag), q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q.size()) begin
                gx = i % 2;
                gy = i / 2;
                chk($sformatf("%s_x%0d", tag, i), q[i].x, gx);
                chk($sformatf("%s_y%0d", tag, i), q[i].y, gy);
                chk($sformatf("%s_ch0_%0d", tag, i), q[i].c0, exp_val(kind, gx, gy, 0, sh, relu));
                chk($sformatf("%s_ch1_%0d", tag, i), q[i].c1, exp_val(kind, gx, gy, 1, sh, relu));
                chk($sformatf("%s_done%0d", tag, i), q[i].done, (i == 3) ? 1 : 0);
                chk($sformatf("%s_lat%0d", tag, i), q[i].cyc,
                    stamp[(gy * 2 + 1) * 4 + gx * 2 + 1] + 2);
            end
        end
        q.delete();
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", o_ot_valid, 0);
        chk("rst_fmap", o_ot_fmap, 0);
        chk("rst_xy", {o_ot_x, o_ot_y}, 0);
        chk("rst_done", o_frame_done, 0);
        chk("rst_sat", o_sat_flag, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Ramp, no shift: (0,0,5) (1,0,7) (0,1,13) (1,1,15)
        send_frame(0, 0, -1);
        check_frame(0, 0, 0, "ramp");
        chk("ramp_sat", o_sat_flag, 0);

        // Shift 2 with saturation to 127 / -128
        i_cfg_shift = 5'd2;
        send_frame(1, 0, -1);
        check_frame(1, 2, 0, "sat");
        chk("sat_flags", o_sat_flag, 3);
        @(negedge clk);
        i_sat_clr = 1'b1;
        @(negedge clk);
        i_sat_clr = 1'b0;
        chk("sat_cleared", o_sat_flag, 0);
        send_frame(2, 0, -1);
        check_frame(2, 2, 0, "shift40");
        chk("shift40_sat", o_sat_flag, 0);

        // ReLU on and off, plus signed max across mixed signs
        i_cfg_shift = 5'd0;
        i_cfg_relu  = 1'b1;
        send_frame(3, 0, -1);
        check_frame(3, 0, 1, "relu1");
        i_cfg_relu = 1'b0;
        send_frame(3, 0, -1);
        check_frame(3, 0, 0, "relu0");
        send_frame(4, 0, -1);
        check_frame(4, 0, 0, "mixed");

        // Gaps with a mid-frame shift change; new shift only takes the next frame
        send_frame(0, 3, 6);
        check_frame(0, 0, 0, "gap");
        send_frame(0, 3, -1);
        check_frame(0, 3, 0, "gapnext");
        i_cfg_shift = 5'd0;

        // Frame resync after 6 junk pixels, resync cycle carries a discarded pixel
        for (int idx = 0; idx < 6; idx++) send_pix(5, idx);
        @(negedge clk);
        i_frame_rst = 1'b1;
        i_in_fmap   = {I_BW'(100), I_BW'(100)};
        @(negedge clk);
        i_frame_rst = 1'b0;
        i_in_valid  = 1'b0;
        repeat (4) @(negedge clk);
        chk("resync_no_out", q.size(), 0);
        send_frame(0, 0, -1);
        check_frame(0, 0, 0, "resync");

        // Async reset between last input and its pooled output
        send_frame(1, 0, -1);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", o_ot_valid, 0);
        chk("arst_fmap", o_ot_fmap, 0);
        chk("arst_sat", o_sat_flag, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_out_count", q.size(), 3);
        q.delete();
        send_frame(0, 0, -1);
        check_frame(0, 0, 0, "post_rst");

        chk("spurious_done", bad_done, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
